// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Streams a program image into an on-chip ROM and holds the core in reset
// until the image is complete. The byte stream is:
//   4 header bytes   : LEN, 32-bit big-endian (first byte is the MSB)
//   LEN payload bytes: written to rom[0 .. LEN-1] in arrival order
//   1 checksum byte  : 8-bit wrap-around sum of the payload, only when
//                      PROGRAM_LOADER_CHECKSUM_EN is defined
//
// Optional build macro:
//   PROGRAM_LOADER_CHECKSUM_EN - adds the CHECK state and checksum logic.
//   Without it, the last payload byte goes straight to DONE.
//
// Ports:
//   clk       in   single clock, rising edge
//   nrst      in   asynchronous active-low reset
//   in_data   in   incoming program byte
//   in_valid  in   in_data holds a valid byte
//   in_ready  out  loader accepts a byte this cycle (registered)
//   reload    in   single-cycle request to restart a load from DONE/ERROR
//   rom       out  program image, ROM_SIZE bytes
//   cpu_nrst  out  active-low core reset, released only once a load completes
//   done      out  load completed successfully
//   error     out  load aborted (oversized LEN or bad checksum)
// -----------------------------------------------------------------------------

package Constants;
  localparam int ROM_SIZE = 16;
  typedef logic [7:0] BYTE;
endpackage

module program_loader #(
  parameter Constants::BYTE FILL_BYTE = 8'h00
) (
  input  logic           clk,
  input  logic           nrst,
  input  Constants::BYTE in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           reload,
  output Constants::BYTE rom [0:Constants::ROM_SIZE-1],
  output logic           cpu_nrst,
  output logic           done,
  output logic           error
);

  localparam int ROM_SIZE = Constants::ROM_SIZE;
  localparam int AW       = $clog2(ROM_SIZE);

  localparam logic [2:0] ST_HEADER  = 3'd0;
  localparam logic [2:0] ST_PAYLOAD = 3'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK   = 3'd2;
`endif
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  // Where a load goes once the payload (possibly empty) has been consumed.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_LOAD_END = ST_CHECK;
`else
  localparam logic [2:0] ST_LOAD_END = ST_DONE;
`endif

  logic [2:0]     state_q,    state_d;
  logic [1:0]     hdr_cnt_q,  hdr_cnt_d;
  logic [31:0]    len_q,      len_d;
  logic [AW-1:0]  addr_q,     addr_d;
  logic           in_ready_q, in_ready_d;
  logic           cpu_nrst_q, cpu_nrst_d;
  logic           done_q,     done_d;
  logic           error_q,    error_d;
  Constants::BYTE rom_q [0:ROM_SIZE-1];
  Constants::BYTE rom_d [0:ROM_SIZE-1];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]     sum_q,      sum_d;
`endif

  logic        accept;
  logic [31:0] hdr_len;
  logic        last_byte;

  // Only the registered ready gates acceptance, so a byte offered while the
  // loader sits in DONE/ERROR is never consumed.
  assign accept    = in_valid & in_ready_q;
  // Header bytes shift in from the right: first byte ends up as the MSB.
  assign hdr_len   = {len_q[23:0], in_data};
  assign last_byte = (32'(addr_q) == (len_q - 32'd1));

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    rom_d     = rom_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    case (state_q)
      ST_HEADER: begin
        if (accept) begin
          len_d     = hdr_len;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            addr_d = '0;
            if (hdr_len > 32'(ROM_SIZE))
              state_d = ST_ERROR;
            else if (hdr_len == 32'd0)
              state_d = ST_LOAD_END;
            else
              state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          // LEN <= ROM_SIZE is guaranteed on entry; the bound on LEN keeps
          // bytes above the image untouched.
          if (32'(addr_q) < len_q)
            rom_d[addr_q] = in_data;
          addr_d = addr_q + AW'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (last_byte)
            state_d = ST_LOAD_END;
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept)
          state_d = (in_data == sum_q) ? ST_DONE : ST_ERROR;
      end
`endif

      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_d   = ST_HEADER;
          hdr_cnt_d = '0;
          len_d     = '0;
          addr_d    = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end

      default: state_d = ST_HEADER;
    endcase

    // Status outputs are a registered decode of the next state, so they
    // change on the same edge the state does. done and error decode
    // distinct states and can never be high together.
    in_ready_d = (state_d == ST_HEADER) || (state_d == ST_PAYLOAD)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                 || (state_d == ST_CHECK)
`endif
                 ;
    done_d     = (state_d == ST_DONE);
    cpu_nrst_d = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_HEADER;
      hdr_cnt_q  <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      cpu_nrst_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
      for (int i = 0; i < ROM_SIZE; i++)
        rom_q[i] <= FILL_BYTE;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      cpu_nrst_q <= cpu_nrst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
      rom_q      <= rom_d;
    end
  end

  assign in_ready = in_ready_q;
  assign cpu_nrst = cpu_nrst_q;
  assign done     = done_q;
  assign error    = error_q;
  assign rom      = rom_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with FILL_BYTE = 8'hAA. Inputs are driven
// and outputs sampled on the falling edge; the DUT acts on the rising edge.
// Expectations adapt when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  localparam logic [7:0] FILL = 8'hAA;
  localparam int         RS   = Constants::ROM_SIZE;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic       reload = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, cpu_nrst, done, error;
  logic [7:0] rom [0:RS-1];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  program_loader #(.FILL_BYTE(FILL)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .reload   (reload),
    .rom      (rom),
    .cpu_nrst (cpu_nrst),
    .done     (done),
    .error    (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One byte offered for one rising edge; gap=1 adds an idle (in_valid=0)
  // cycle carrying junk data afterwards.
  task automatic push(input logic [7:0] b, input bit gap);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    if (gap) begin
      in_data = 8'hEE;
      @(negedge clk);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Asynchronous reset from a falling edge, checked while still asserted.
  task automatic do_reset(input string tag);
    nrst     = 1'b0;
    in_valid = 1'b0;
    reload   = 1'b0;
    #1;
    for (int i = 0; i < RS; i++) chk($sformatf("%s rom[%0d]", tag, i), rom[i], FILL);
    chk({tag, " in_ready low"}, in_ready, 1'b0);
    chk({tag, " cpu_nrst low"}, cpu_nrst, 1'b0);
    chk({tag, " done low"}, done, 1'b0);
    chk({tag, " error low"}, error, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    #1 chk({tag, " in_ready before edge"}, in_ready, 1'b0);
    @(negedge clk);
    chk({tag, " in_ready after edge"}, in_ready, 1'b1);
    chk({tag, " cpu_nrst still low"}, cpu_nrst, 1'b0);
  endtask

  logic [7:0] s4 [0:7];
  logic [7:0] sum;

  initial begin
    s4[0] = 8'h00; s4[1] = 8'h00; s4[2] = 8'h00; s4[3] = 8'h04;
    s4[4] = 8'h3C; s4[5] = 8'h01; s4[6] = 8'h12; s4[7] = 8'h34;

    // Power-on reset and release
    @(negedge clk);
    do_reset("rst0");

    // 4-byte load, in_valid held high
    for (int i = 0; i < 7; i++) push(s4[i], 1'b0);
    chk("t2 done before last", done, 1'b0);
    chk("t2 cpu_nrst before last", cpu_nrst, 1'b0);
    push(s4[7], 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk("t2 in CHECK ready", in_ready, 1'b1);
    chk("t2 done before checksum", done, 1'b0);
    push(8'h83, 1'b0);
`endif
    chk("t2 done", done, 1'b1);
    chk("t2 cpu_nrst", cpu_nrst, 1'b1);
    chk("t2 error", error, 1'b0);
    chk("t2 in_ready", in_ready, 1'b0);
    chk("t2 rom0", rom[0], 8'h3C);
    chk("t2 rom1", rom[1], 8'h01);
    chk("t2 rom2", rom[2], 8'h12);
    chk("t2 rom3", rom[3], 8'h34);
    chk("t2 rom4", rom[4], FILL);

    // Reload keeps the image, restarts handshake
    do_reload();
    chk("rl done", done, 1'b0);
    chk("rl cpu_nrst", cpu_nrst, 1'b0);
    chk("rl error", error, 1'b0);
    chk("rl in_ready", in_ready, 1'b1);
    chk("rl rom0", rom[0], 8'h3C);
    chk("rl rom3", rom[3], 8'h34);

    // Same stream with in_valid toggling, from a cleared ROM
    do_reset("rst1");
    for (int i = 0; i < 8; i++) push(s4[i], 1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    push(8'h83, 1'b1);
`endif
    chk("t3 done", done, 1'b1);
    chk("t3 rom0", rom[0], 8'h3C);
    chk("t3 rom1", rom[1], 8'h01);
    chk("t3 rom2", rom[2], 8'h12);
    chk("t3 rom3", rom[3], 8'h34);
    chk("t3 rom4", rom[4], FILL);

    // Oversized header LEN = ROM_SIZE+1
    do_reload();
    push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0);
    chk("t4 error before 4th", error, 1'b0);
    push(8'(RS + 1), 1'b0);
    chk("t4 error", error, 1'b1);
    chk("t4 done", done, 1'b0);
    chk("t4 in_ready", in_ready, 1'b0);
    chk("t4 cpu_nrst", cpu_nrst, 1'b0);
    chk("t4 rom0", rom[0], 8'h3C);
    chk("t4 rom4", rom[4], FILL);

    // LEN = 0
    do_reload();
    chk("t5 error cleared", error, 1'b0);
    for (int i = 0; i < 4; i++) push(8'h00, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk("t5 done before checksum", done, 1'b0);
    push(8'h00, 1'b0);
`endif
    chk("t5 done", done, 1'b1);
    chk("t5 cpu_nrst", cpu_nrst, 1'b1);
    chk("t5 rom0", rom[0], 8'h3C);

    // LEN = ROM_SIZE fills the whole ROM
    do_reload();
    push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'(RS), 1'b0);
    sum = 8'h00;
    for (int i = 0; i < RS; i++) begin
      push(8'(i * 7 + 1), 1'b0);
      sum = sum + 8'(i * 7 + 1);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    push(sum, 1'b0);
`endif
    chk("t6 done", done, 1'b1);
    chk("t6 error", error, 1'b0);
    chk("t6 rom0", rom[0], 8'h01);
    chk("t6 rom last", rom[RS-1], 8'((RS - 1) * 7 + 1));

    // Shorter load leaves bytes above LEN alone
    do_reload();
    push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h02, 1'b0);
    push(8'hC1, 1'b0); push(8'hC2, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    push(8'h83, 1'b0);
`endif
    chk("t6b done", done, 1'b1);
    chk("t6b rom0", rom[0], 8'hC1);
    chk("t6b rom1", rom[1], 8'hC2);
    chk("t6b rom2 kept", rom[2], 8'h0F);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Checksum good then bad
    do_reload();
    push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h03, 1'b0);
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h06, 1'b0);
    chk("t7 good done", done, 1'b1);
    chk("t7 good error", error, 1'b0);
    do_reload();
    push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h03, 1'b0);
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h07, 1'b0);
    chk("t7 bad error", error, 1'b1);
    chk("t7 bad done", done, 1'b0);
    chk("t7 bad cpu_nrst", cpu_nrst, 1'b0);
`endif

    // Reset mid-payload, then a fresh load with reload asserted mid-load
    do_reload();
    push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h04, 1'b0);
    push(8'hAB, 1'b0); push(8'hCD, 1'b0);
    chk("t8 rom0 written", rom[0], 8'hAB);
    chk("t8 done mid", done, 1'b0);
    do_reset("rst2");
    push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h02, 1'b0);
    reload = 1'b1;
    push(8'h55, 1'b0);
    reload = 1'b0;
    push(8'h66, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    push(8'hBB, 1'b0);
`endif
    chk("t8 done", done, 1'b1);
    chk("t8 cpu_nrst", cpu_nrst, 1'b1);
    chk("t8 rom0", rom[0], 8'h55);
    chk("t8 rom1", rom[1], 8'h66);
    chk("t8 rom2", rom[2], FILL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
